// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
// Shared frame definitions for the monitor UART link (RX parser and TX framer).
//   FRAME_H1 / FRAME_H2   : two-byte frame header (EB 9C)
//   FRAME_PAYLOAD_BYTES   : payload length in bytes
//   CHK_SEED              : checksum value after both header bytes (EB+9C mod 256)
//   frame_state_e         : parser state encoding
//   chk_add()             : 8-bit wrap-around checksum accumulate
// -----------------------------------------------------------------------------
package uart_frame_pkg;

   localparam logic [7:0] FRAME_H1            = 8'hEB;
   localparam logic [7:0] FRAME_H2            = 8'h9C;
   localparam int         FRAME_PAYLOAD_BYTES = 8;
   localparam logic [7:0] CHK_SEED            = 8'h87;

   typedef enum logic [2:0] {
      HUNT_H1 = 3'd0,
      HUNT_H2 = 3'd1,
      PAYLOAD = 3'd2,
      CHK     = 3'd3,
      DONE    = 3'd4
   } frame_state_e;

   function automatic logic [7:0] chk_add(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/uart_rx_timer.sv
// -----------------------------------------------------------------------------
// uart_rx_timer
// Inter-byte timeout counter for the frame parser.
//   clk, rst   : clock, synchronous active-high reset
//   i_clr      : clear the count (byte seen, or parser idle)
//   i_run      : count this cycle (parser inside a frame)
//   o_expire   : single-cycle pulse when the count reaches TIMEOUT_CYC-1
//                while running and not being cleared
// The count saturates at all-ones so a stuck i_run can never wrap it.
// -----------------------------------------------------------------------------
module uart_rx_timer #(
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_run,
   output logic o_expire
);

   localparam int             CW   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_run && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // A byte in the same cycle clears the timer and therefore wins.
   assign o_expire = i_run & ~i_clr & (r_cnt == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// -----------------------------------------------------------------------------
// uart_frame_rx
// Receive-side frame parser for the monitor UART link. Hunts for header EB 9C,
// collects 8 payload bytes LS byte first into a 64-bit word, optionally checks
// a trailing additive checksum, and abandons frames stalled longer than
// TIMEOUT_CYC cycles between bytes.
//   clk, rst       : clock, synchronous active-high reset
//   I_rx_en        : byte strobe (one byte per high cycle)
//   I_rx_data      : received byte, valid with I_rx_en
//   O_data         : last good payload, byte k at [8k+7:8k]
//   O_data_valid   : 1-cycle pulse when O_data is updated
//   O_crc_err      : 1-cycle pulse on checksum mismatch
//   O_timeout      : 1-cycle pulse when a partial frame is abandoned
// All three pulses and O_data are registered; they appear the cycle after the
// byte (or idle cycle) that caused them.
// -----------------------------------------------------------------------------
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int CHECKSUM_EN = 0,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        I_rx_en,
   input  logic [7:0]  I_rx_data,
   output logic [63:0] O_data,
   output logic        O_data_valid,
   output logic        O_crc_err,
   output logic        O_timeout
);

   frame_state_e r_state, w_nxt_state;
   logic [2:0]   r_idx,   w_nxt_idx;
   logic [63:0]  r_shreg, w_nxt_shreg;
   logic [7:0]   r_chk,   w_nxt_chk;
   logic [63:0]  r_data,  w_nxt_data;
   logic         r_vld,   w_nxt_vld;
   logic         r_crc,   w_nxt_crc;
   logic         r_to,    w_nxt_to;

   logic         w_in_frame;
   logic         w_expire;
   logic [63:0]  w_word;

   // HUNT_H1 and DONE are both "between frames": timer held clear.
   assign w_in_frame = (r_state == HUNT_H2) || (r_state == PAYLOAD) || (r_state == CHK);

   uart_rx_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (I_rx_en | ~w_in_frame),
      .i_run    (w_in_frame),
      .o_expire (w_expire)
   );

   // Shift register with the current byte dropped into its slot.
   always_comb begin
      w_word = r_shreg;
      w_word[{r_idx, 3'b000} +: 8] = I_rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= HUNT_H1;
         r_idx   <= '0;
         r_shreg <= '0;
         r_chk   <= '0;
         r_data  <= '0;
         r_vld   <= 1'b0;
         r_crc   <= 1'b0;
         r_to    <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_idx   <= w_nxt_idx;
         r_shreg <= w_nxt_shreg;
         r_chk   <= w_nxt_chk;
         r_data  <= w_nxt_data;
         r_vld   <= w_nxt_vld;
         r_crc   <= w_nxt_crc;
         r_to    <= w_nxt_to;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_idx   = r_idx;
      w_nxt_shreg = r_shreg;
      w_nxt_chk   = r_chk;
      w_nxt_data  = r_data;
      w_nxt_vld   = 1'b0;
      w_nxt_crc   = 1'b0;
      w_nxt_to    = 1'b0;

      if (w_expire) begin
         w_nxt_state = HUNT_H1;
         w_nxt_to    = 1'b1;
      end else if (I_rx_en) begin
         unique case (r_state)
            // DONE only exists to mark the valid cycle; a byte arriving then
            // is treated exactly like a first-header candidate.
            HUNT_H1, DONE: begin
               w_nxt_state = (I_rx_data == FRAME_H1) ? HUNT_H2 : HUNT_H1;
            end
            HUNT_H2: begin
               if (I_rx_data == FRAME_H2) begin
                  w_nxt_state = PAYLOAD;
                  w_nxt_idx   = '0;
                  w_nxt_chk   = CHK_SEED;
                  w_nxt_shreg = '0;
               end else if (I_rx_data == FRAME_H1) begin
                  w_nxt_state = HUNT_H2;
               end else begin
                  w_nxt_state = HUNT_H1;
               end
            end
            PAYLOAD: begin
               w_nxt_shreg = w_word;
               w_nxt_chk   = chk_add(r_chk, I_rx_data);
               w_nxt_idx   = r_idx + 3'd1;
               if (r_idx == 3'(FRAME_PAYLOAD_BYTES - 1)) begin
                  if (CHECKSUM_EN != 0) begin
                     w_nxt_state = CHK;
                  end else begin
                     w_nxt_state = DONE;
                     w_nxt_data  = w_word;
                     w_nxt_vld   = 1'b1;
                  end
               end
            end
            CHK: begin
               if (I_rx_data == r_chk) begin
                  w_nxt_state = DONE;
                  w_nxt_data  = r_shreg;
                  w_nxt_vld   = 1'b1;
               end else begin
                  w_nxt_state = HUNT_H1;
                  w_nxt_crc   = 1'b1;
               end
            end
            default: w_nxt_state = HUNT_H1;
         endcase
      end else if (r_state == DONE) begin
         w_nxt_state = HUNT_H1;
      end
   end

   assign O_data       = r_data;
   assign O_data_valid = r_vld;
   assign O_crc_err    = r_crc;
   assign O_timeout    = r_to;

endmodule

// File: tb/tb_uart_frame_rx.sv
module tb_uart_frame_rx;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst0 = 1'b1, rst1 = 1'b1;
   logic        en0 = 1'b0, en1 = 1'b0;
   logic [7:0]  dat0 = 8'h00, dat1 = 8'h00;
   logic [63:0] odata0, odata1;
   logic        ovld0, ovld1, ocrc0, ocrc1, oto0, oto1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_frame_rx #(.CHECKSUM_EN(0), .TIMEOUT_CYC(T)) dut0 (
      .clk(clk), .rst(rst0), .I_rx_en(en0), .I_rx_data(dat0),
      .O_data(odata0), .O_data_valid(ovld0), .O_crc_err(ocrc0), .O_timeout(oto0));

   uart_frame_rx #(.CHECKSUM_EN(1), .TIMEOUT_CYC(T)) dut1 (
      .clk(clk), .rst(rst1), .I_rx_en(en1), .I_rx_data(dat1),
      .O_data(odata1), .O_data_valid(ovld1), .O_crc_err(ocrc1), .O_timeout(oto1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: byte list of the candidate frame
   logic [7:0]  mbuf [2][11];
   int          mlen [2];
   int          midle[2];
   logic [63:0] m_data[2];
   bit          m_vld[2], m_crc[2], m_to[2];

   task automatic model_step(input int d, input int ce, input bit r, input bit e, input logic [7:0] b);
      logic [7:0]  sum;
      logic [63:0] word;
      m_vld[d] = 0; m_crc[d] = 0; m_to[d] = 0;
      if (r) begin
         mlen[d] = 0; midle[d] = 0; m_data[d] = '0;
         return;
      end
      if (e) begin
         midle[d] = 0;
         if (mlen[d] == 0) begin
            if (b == 8'hEB) begin mbuf[d][0] = b; mlen[d] = 1; end
         end else if (mlen[d] == 1) begin
            if (b == 8'h9C) begin mbuf[d][1] = b; mlen[d] = 2; end
            else if (b != 8'hEB) mlen[d] = 0;
         end else begin
            mbuf[d][mlen[d]] = b;
            mlen[d]++;
            if (mlen[d] == 10 + ce) begin
               sum = 8'h00;
               for (int i = 0; i < 10; i++) sum = sum + mbuf[d][i];
               for (int k = 0; k < 8; k++) word[8*k +: 8] = mbuf[d][2+k];
               if (ce != 0 && mbuf[d][10] != sum) m_crc[d] = 1;
               else begin m_vld[d] = 1; m_data[d] = word; end
               mlen[d] = 0;
            end
         end
      end else if (mlen[d] > 0) begin
         midle[d]++;
         if (midle[d] >= T) begin
            m_to[d] = 1; mlen[d] = 0; midle[d] = 0;
         end
      end
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   initial begin
      forever begin
         @(posedge clk);
         model_step(0, 0, rst0, en0, dat0);
         model_step(1, 1, rst1, en1, dat1);
         @(negedge clk);
         chk("d0_data",    odata0, m_data[0]);
         chk("d0_valid",   64'(ovld0), 64'(m_vld[0]));
         chk("d0_crc_err", 64'(ocrc0), 64'(m_crc[0]));
         chk("d0_timeout", 64'(oto0),  64'(m_to[0]));
         chk("d1_data",    odata1, m_data[1]);
         chk("d1_valid",   64'(ovld1), 64'(m_vld[1]));
         chk("d1_crc_err", 64'(ocrc1), 64'(m_crc[1]));
         chk("d1_timeout", 64'(oto1),  64'(m_to[1]));
      end
   end

   // One call = one clock cycle of input; returns just after the edge.
   task automatic put(input int d, input bit r, input bit e, input logic [7:0] b);
      if (d == 0) begin rst0 = r; en0 = e; dat0 = b; end
      else        begin rst1 = r; en1 = e; dat1 = b; end
      @(posedge clk);
      #1;
   endtask

   task automatic sendb(input int d, input logic [7:0] b);
      put(d, 1'b0, 1'b1, b);
   endtask

   task automatic idle(input int d, input int n);
      for (int i = 0; i < n; i++) put(d, 1'b0, 1'b0, 8'h00);
   endtask

   // Header followed by 8 bytes base+1 .. base+8.
   task automatic frame(input int d, input logic [7:0] base);
      sendb(d, 8'hEB);
      sendb(d, 8'h9C);
      for (int i = 1; i <= 8; i++) sendb(d, base + 8'(i));
   endtask

   int tcount;

   initial begin
      put(0, 1'b1, 1'b0, 8'h00);
      put(1, 1'b1, 1'b0, 8'h00);
      chk("reset_data",  odata0, 64'h0);
      chk("reset_flags", {61'h0, ovld0, ocrc0, oto0}, 64'h0);
      put(0, 1'b0, 1'b0, 8'h00);
      put(1, 1'b0, 1'b0, 8'h00);

      // 1: basic frame, valid one cycle after last strobe
      frame(0, 8'h00);
      chk("t1_valid_now", 64'(ovld0), 64'h1);
      chk("t1_data",      odata0, 64'h0807060504030201);
      chk("t1_model",     m_data[0], 64'h0807060504030201);
      idle(0, 1);
      chk("t1_valid_once", 64'(ovld0), 64'h0);

      // 2: resync on EB EB 9C, then a broken header
      sendb(0, 8'hEB);
      frame(0, 8'h10);
      chk("t2_resync_data", odata0, 64'h1817161514131211);
      idle(0, 2);
      sendb(0, 8'h55); sendb(0, 8'hEB); sendb(0, 8'h00); sendb(0, 8'h9C);
      for (int i = 1; i <= 8; i++) sendb(0, 8'(i));
      idle(0, 3);
      chk("t2_data_kept", odata0, 64'h1817161514131211);

      // 4: timeout after partial frame, recovery, byte just in time
      sendb(0, 8'hEB); sendb(0, 8'h9C);
      sendb(0, 8'h01); sendb(0, 8'h02); sendb(0, 8'h03);
      tcount = 0;
      for (int i = 0; i < T + 3; i++) begin
         idle(0, 1);
         if (oto0) tcount++;
      end
      chk("t4_timeout_cnt", 64'(tcount), 64'h1);
      frame(0, 8'hA0);
      chk("t4_recover", odata0, 64'hA8A7A6A5A4A3A2A1);
      tcount = 0;
      sendb(0, 8'hEB); sendb(0, 8'h9C); sendb(0, 8'h01);
      for (int i = 0; i < T - 1; i++) begin
         idle(0, 1);
         if (oto0) tcount++;
      end
      for (int i = 2; i <= 8; i++) sendb(0, 8'(i));
      chk("t4_late_byte_valid", 64'(ovld0), 64'h1);
      chk("t4_late_byte_no_to", 64'(tcount), 64'h0);

      // 5: reset mid-frame
      sendb(0, 8'hEB); sendb(0, 8'h9C);
      for (int i = 1; i <= 4; i++) sendb(0, 8'(i));
      put(0, 1'b1, 1'b0, 8'h00);
      chk("t5_rst_data",  odata0, 64'h0);
      chk("t5_rst_flags", {61'h0, ovld0, ocrc0, oto0}, 64'h0);
      put(0, 1'b0, 1'b0, 8'h00);
      frame(0, 8'hC0);
      chk("t5_after_rst", odata0, 64'hC8C7C6C5C4C3C2C1);

      // 6: back-to-back frames, strobe every cycle
      frame(0, 8'h20);
      chk("t6_first_valid", 64'(ovld0), 64'h1);
      chk("t6_first_data",  odata0, 64'h2827262524232221);
      frame(0, 8'h30);
      chk("t6_second_valid", 64'(ovld0), 64'h1);
      chk("t6_second_data",  odata0, 64'h3837363534333231);
      idle(0, 2);

      // 3: checksum variant
      frame(1, 8'h00);
      sendb(1, 8'hAB);
      chk("t3_chk_valid", 64'(ovld1), 64'h1);
      chk("t3_chk_data",  odata1, 64'h0807060504030201);
      idle(1, 1);
      frame(1, 8'h10);
      sendb(1, 8'h2B);
      chk("t3_chk_data2", odata1, 64'h1817161514131211);
      frame(1, 8'h00);
      sendb(1, 8'hAC);
      chk("t3_crc_err",   64'(ocrc1), 64'h1);
      chk("t3_crc_novld", 64'(ovld1), 64'h0);
      chk("t3_crc_kept",  odata1, 64'h1817161514131211);
      idle(1, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
